// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: geometry defaults and gray-code helpers
// used by both the write-side and read-side controllers.
package fifo_pkg;

  localparam int P_SIZE_DEF = 4;
  localparam int ADDR_W     = P_SIZE_DEF - 1;
  localparam int DEPTH      = 1 << ADDR_W;

  // Helpers work on a 32-bit container; callers zero-extend and slice.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing into this clock
// domain; the read side reuses it for the write pointer.
module fifo_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift chain; the first stage is the only one that may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: write pointer, memory strobe,
// gray pointer export, synchronised read pointer and full/level/overflow flags.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int P_SIZE      = P_SIZE_DEF,
  parameter int AF_THRESH   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic              ovf_clr,
  input  logic [P_SIZE-1:0] gray_rd_ptr,
  output logic              wr_en,
  output logic [P_SIZE-2:0] wr_addr,
  output logic [P_SIZE-1:0] gray_wr_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [P_SIZE-1:0] wr_level,
  output logic              overflow
);

  localparam logic [P_SIZE-1:0] AF_LEVEL = P_SIZE'(AF_THRESH);

  logic [P_SIZE-1:0] wr_ptr;
  logic [P_SIZE-1:0] sync_rd;
  logic [P_SIZE-1:0] rd_bin;
  logic [P_SIZE-1:0] wr_gray_now;
  logic [31:0]       gray_wide;
  logic [31:0]       bin_wide;
  logic              conv_unused;

  fifo_ptr_sync #(
    .WIDTH  (P_SIZE),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (w_clk),
    .rst (w_rst),
    .d   (gray_rd_ptr),
    .q   (sync_rd)
  );

  // Pointer conversions, narrowed back to the pointer width.
  always_comb begin
    gray_wide   = bin2gray(32'(wr_ptr));
    bin_wide    = gray2bin(32'(sync_rd));
    wr_gray_now = gray_wide[P_SIZE-1:0];
    rd_bin      = bin_wide[P_SIZE-1:0];
  end

  assign conv_unused = ^{gray_wide[31:P_SIZE], bin_wide[31:P_SIZE]};

  // Full when the pointers differ only in the wrap bit, compared in gray form.
  assign full        = (wr_gray_now == {~sync_rd[P_SIZE-1:P_SIZE-2], sync_rd[P_SIZE-3:0]});
  assign wr_level    = wr_ptr - rd_bin;
  assign almost_full = (wr_level >= AF_LEVEL);
  assign wr_en       = w_inc & ~full & ~w_rst;
  assign wr_addr     = wr_ptr[P_SIZE-2:0];

  // Overflow set has priority over a same-cycle clear so no event is lost.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wr_ptr      <= '0;
      gray_wr_ptr <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + P_SIZE'(1);
      end
      gray_wr_ptr <= wr_gray_now;
      if (w_inc & full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: cycle model of pointers and flags plus
// a write-address scoreboard, driven by a directed step sequence.
module tb_fifo_wr_ctrl;
  import fifo_pkg::*;

  logic       w_clk;
  logic       w_rst;
  logic       w_inc;
  logic       ovf_clr;
  logic [3:0] gray_rd_ptr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] gray_wr_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_ptr, m_gray, m_s0, m_s1;
  logic       m_ovf;
  logic [2:0] addr_q[$];

  fifo_wr_ctrl #(
    .P_SIZE      (4),
    .AF_THRESH   (6),
    .SYNC_STAGES (2)
  ) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_inc       (w_inc),
    .ovf_clr     (ovf_clr),
    .gray_rd_ptr (gray_rd_ptr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .gray_wr_ptr (gray_wr_ptr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [3:0] tb_b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the parity of all gray bits at or above it.
  function automatic logic [3:0] tb_g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare pre-edge outputs to the model, then clock it.
  task automatic applyStimulus(input logic rst, input logic inc, input logic clr,
                               input logic [3:0] grd);
    logic [3:0] lvl;
    logic       mfull;
    logic       mwr;
    w_rst = rst; w_inc = inc; ovf_clr = clr; gray_rd_ptr = grd;
    #1;
    lvl   = m_ptr - tb_g2b(m_s1);
    mfull = (lvl == 4'd8);
    mwr   = inc & ~rst & ~mfull;
    if (mwr) addr_q.push_back(m_ptr[2:0]);
    checkOutput("wr_en", wr_en, mwr);
    checkOutput("full", full, mfull);
    checkOutput("wr_level", wr_level, lvl);
    checkOutput("almost_full", almost_full, lvl >= 4'd6);
    checkOutput("gray_wr_ptr", gray_wr_ptr, m_gray);
    checkOutput("overflow", overflow, m_ovf);
    if (wr_en === 1'b1) begin
      checkOutput("sb_depth", addr_q.size(), 1);
      if (addr_q.size() > 0) checkOutput("wr_addr", wr_addr, addr_q.pop_front());
    end
    @(posedge w_clk);
    if (rst) begin
      m_ptr = 0; m_gray = 0; m_s0 = 0; m_s1 = 0; m_ovf = 0;
    end else begin
      m_gray = tb_b2g(m_ptr);
      m_s1   = m_s0;
      m_s0   = grd;
      if (inc && mfull) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (mwr) m_ptr = m_ptr + 4'd1;
    end
    #1;
  endtask

  initial begin
    logic [3:0] prev_gray;
    m_ptr = 0; m_gray = 0; m_s0 = 0; m_s1 = 0; m_ovf = 0;
    w_rst = 1'b1; w_inc = 1'b1; ovf_clr = 1'b0; gray_rd_ptr = 4'd0;
    @(posedge w_clk);
    #1;

    // Reset held with write requests pending.
    applyStimulus(1, 1, 0, 4'd0);
    applyStimulus(1, 1, 0, 4'd0);
    checkOutput("t1_level", wr_level, 0);
    checkOutput("t1_addr", wr_addr, 0);
    checkOutput("t1_full", full, 0);

    // Fill to depth.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 4'd0);
    checkOutput("t2_full", full, 1);
    checkOutput("t2_level", wr_level, 8);
    checkOutput("t2_af", almost_full, 1);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("t2_gray", gray_wr_ptr, 4'b1100);

    // Writes while full, overflow clear and set-beats-clear.
    applyStimulus(0, 1, 0, 4'd0);
    checkOutput("t3_addr", wr_addr, 0);
    checkOutput("t3_level", wr_level, 8);
    checkOutput("t3_ovf_set", overflow, 1);
    applyStimulus(0, 0, 1, 4'd0);
    checkOutput("t3_ovf_clr", overflow, 0);
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 1, 1, 4'd0);
    checkOutput("t3_ovf_prio", overflow, 1);

    // Read pointer advances to 2; flags follow after the sync latency.
    applyStimulus(0, 0, 0, 4'b0011);
    checkOutput("t4_full_hold", full, 1);
    checkOutput("t4_level_hold", wr_level, 8);
    applyStimulus(0, 0, 0, 4'b0011);
    checkOutput("t4_full_drop", full, 0);
    checkOutput("t4_level", wr_level, 6);
    checkOutput("t4_af", almost_full, 1);

    // Wrap with a tracking reader.
    applyStimulus(1, 0, 0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      prev_gray = gray_wr_ptr;
      applyStimulus(0, 1, 0, tb_b2g(m_ptr));
      if (i > 0) checkOutput("t5_gray_1bit", $countones(gray_wr_ptr ^ prev_gray), 1);
    end
    checkOutput("t5_addr", wr_addr, 4);

    // Reach wr_ptr=5 with overflow set, then reset mid-operation.
    applyStimulus(0, 0, 0, 4'b1011);
    applyStimulus(0, 0, 0, 4'b1011);
    checkOutput("t6_level", wr_level, 7);
    applyStimulus(0, 1, 0, 4'b1011);
    checkOutput("t6_addr", wr_addr, 5);
    checkOutput("t6_full", full, 1);
    applyStimulus(0, 1, 0, 4'b1011);
    checkOutput("t6_ovf", overflow, 1);
    applyStimulus(1, 1, 0, 4'b1011);
    checkOutput("t6_rst_level", wr_level, 0);
    checkOutput("t6_rst_addr", wr_addr, 0);
    checkOutput("t6_rst_gray", gray_wr_ptr, 0);
    checkOutput("t6_rst_ovf", overflow, 0);
    checkOutput("t6_rst_full", full, 0);
    applyStimulus(0, 0, 0, 4'b1011);

    checkOutput("sb_drain", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
